// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS fetch/decode front end.
// FETCH_MISALIGN_TRAP_EN adds the StErr fetch state.
package cpu_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFetch = 2'b01,
    StHold  = 2'b10
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    StErr   = 2'b11
`endif
  } fetch_state_e;

  // Word-aligned, sign-extended byte offset of a branch immediate.
  function automatic logic [INSTR_W-1:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection for the fetch stage: jr > jump > branch > sequential.
// Low two bits of a jr target are always cleared here (FETCH_MISALIGN_TRAP_EN traps upstream).
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] i_pc,
  input  logic               i_br_taken,
  input  logic [15:0]        i_br_imm,
  input  logic               i_jump,
  input  logic [25:0]        i_jump_idx,
  input  logic               i_jr,
  input  logic [INSTR_W-1:0] i_jr_target,
  output logic [INSTR_W-1:0] o_next_pc,
  output logic [INSTR_W-1:0] o_pc_plus4
);

  logic [INSTR_W-1:0] w_pc_plus4;
  logic [INSTR_W-1:0] w_br_target;
  logic [INSTR_W-1:0] w_jump_target;
  logic [INSTR_W-1:0] w_jr_target;

  assign w_pc_plus4    = i_pc + 32'd4;
  assign w_br_target   = w_pc_plus4 + branch_offset(i_br_imm);
  // Jump stays within the 256 MB region of the delay-slot address.
  assign w_jump_target = {w_pc_plus4[31:28], i_jump_idx, 2'b00};
  assign w_jr_target   = i_jr_target & 32'hFFFF_FFFC;

  always_comb begin
    o_next_pc = w_pc_plus4;
    if (i_jr) begin
      o_next_pc = w_jr_target;
    end else if (i_jump) begin
      o_next_pc = w_jump_target;
    end else if (i_br_taken) begin
      o_next_pc = w_br_target;
    end
  end

  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a req/ready handshake, holds until ack.
// FETCH_MISALIGN_TRAP_EN: misaligned jr target parks the stage in StErr with addr_err set.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    op,
  output logic [INSTR_W-1:0] pc,
  output logic [INSTR_W-1:0] pc_plus4,
  output logic               instr_valid,
  input  logic               instr_ack,
  input  logic               br_taken,
  input  logic [15:0]        br_imm,
  input  logic               jump,
  input  logic [25:0]        jump_idx,
  input  logic               jr,
  input  logic [INSTR_W-1:0] jr_target,
  output logic               addr_err
);

  fetch_state_e       r_state;
  logic [INSTR_W-1:0] r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_imem_req;
  logic               r_instr_valid;
  logic [INSTR_W-1:0] w_next_pc;
  logic [INSTR_W-1:0] w_pc_plus4;

  next_pc_calc u_next_pc_calc (
    .i_pc        (r_pc),
    .i_br_taken  (br_taken),
    .i_br_imm    (br_imm),
    .i_jump      (jump),
    .i_jump_idx  (jump_idx),
    .i_jr        (jr),
    .i_jr_target (jr_target),
    .o_next_pc   (w_next_pc),
    .o_pc_plus4  (w_pc_plus4)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_addr_err;
  logic w_jr_misaligned;

  assign w_jr_misaligned = jr && (jr_target[1:0] != 2'b00);
  assign addr_err        = r_addr_err;
`else
  assign addr_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_addr_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          r_state    <= StFetch;
          r_imem_req <= 1'b1;
        end
        StFetch: begin
          if (imem_ready) begin
            r_instr       <= imem_rdata;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= StHold;
          end
        end
        StHold: begin
          if (instr_ack) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (w_jr_misaligned) begin
              r_state       <= StErr;
              r_instr_valid <= 1'b0;
              r_addr_err    <= 1'b1;
            end else
`endif
            begin
              r_pc          <= w_next_pc;
              r_state       <= StFetch;
              r_imem_req    <= 1'b1;
              r_instr_valid <= 1'b0;
            end
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        // Terminal until reset.
        StErr: begin
          r_state <= StErr;
        end
`endif
        default: begin
          r_state       <= StIdle;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign op          = r_instr[31:26];
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch; expectations follow FETCH_MISALIGN_TRAP_EN when defined.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ack;
  logic        br_taken;
  logic [15:0] br_imm;
  logic        jump;
  logic [25:0] jump_idx;
  logic        jr;
  logic [31:0] jr_target;
  logic        addr_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_hold[$];
  logic        m_prev_valid;
  logic [31:0] m_a;

  // Memory model: opcode field carries addr[7:2] so op is checkable per address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[7:2], a[25:0] ^ 26'h2AA_AAAA};
  endfunction

  assign imem_rdata = word_at(imem_addr);

  instruction_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .op          (op),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .instr_ack   (instr_ack),
    .br_taken    (br_taken),
    .br_imm      (br_imm),
    .jump        (jump),
    .jump_idx    (jump_idx),
    .jr          (jr),
    .jr_target   (jr_target),
    .addr_err    (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a);
    q_addr.push_back(a);
    q_hold.push_back(a);
  endtask

  task automatic wait_valid(output int cyc, input int budget);
    cyc = 0;
    while (!instr_valid && cyc < budget) begin
      tick();
      cyc++;
    end
    check("wait_valid", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic ack(input logic a_jr, input logic [31:0] a_jrt, input logic a_jump,
                     input logic [25:0] a_idx, input logic a_br, input logic [15:0] a_imm,
                     input logic exp_req);
    jr        = a_jr;
    jr_target = a_jrt;
    jump      = a_jump;
    jump_idx  = a_idx;
    br_taken  = a_br;
    br_imm    = a_imm;
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    jr        = 1'b0;
    jump      = 1'b0;
    br_taken  = 1'b0;
    check("ack_to_req", {31'd0, imem_req}, {31'd0, exp_req});
  endtask

  // Monitor: pops expectations when a fetch is accepted and when a new instr is presented.
  initial begin
    m_prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && imem_req && imem_ready) begin
        if (q_addr.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL fetch_unexpected: got fetch of 0x%08h, expected none", imem_addr);
        end else begin
          check("fetch_addr", imem_addr, q_addr.pop_front());
        end
      end
      if (!rst && instr_valid && !m_prev_valid) begin
        if (q_hold.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL hold_unexpected: got instr at pc 0x%08h, expected none", pc);
        end else begin
          m_a = q_hold.pop_front();
          check("hold_pc", pc, m_a);
          check("hold_instr", instr, word_at(m_a));
          check("hold_op", {26'd0, op}, {26'd0, m_a[7:2]});
          check("hold_pc_plus4", pc_plus4, m_a + 32'd4);
        end
      end
      m_prev_valid = instr_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    rst        = 1'b1;
    imem_ready = 1'b0;
    instr_ack  = 1'b0;
    br_taken   = 1'b0;
    br_imm     = '0;
    jump       = 1'b0;
    jump_idx   = '0;
    jr         = 1'b0;
    jr_target  = '0;
    tick();
    tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", pc, 32'h0000_0000);
    check("rst_instr", instr, 32'h0000_0000);
    check("rst_addr_err", {31'd0, addr_err}, 32'd0);
    check("rst_pc_plus4", pc_plus4, 32'h0000_0004);

    // Sequential, zero-wait memory, ack in first hold cycle.
    push_exp(32'h0);
    rst        = 1'b0;
    imem_ready = 1'b1;
    check("idle_no_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr0", imem_addr, 32'h0);
    wait_valid(cyc, 10);
    check("first_latency", cyc, 1);
    for (int i = 1; i < 4; i++) begin
      push_exp(32'(i * 4));
      ack(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b1);
      check("seq_addr", imem_addr, 32'(i * 4));
      check("valid_gap", {31'd0, instr_valid}, 32'd0);
      wait_valid(cyc, 10);
      check("throughput", cyc, 1);
    end

    // Branches from pc=0x100.
    push_exp(32'h100);
    ack(1'b1, 32'h100, 1'b0, 26'h0, 1'b0, 16'h0, 1'b1);
    wait_valid(cyc, 10);
    push_exp(32'h0FC);
    ack(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 16'hFFFE, 1'b1);
    check("br_back", imem_addr, 32'h0FC);
    wait_valid(cyc, 10);
    push_exp(32'h100);
    ack(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b1);
    wait_valid(cyc, 10);
    push_exp(32'h110);
    ack(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 16'h0003, 1'b1);
    check("br_fwd", imem_addr, 32'h110);
    wait_valid(cyc, 10);

    // Jump beats branch; jr beats jump.
    push_exp(32'h3000_0010);
    ack(1'b1, 32'h3000_0010, 1'b0, 26'h0, 1'b0, 16'h0, 1'b1);
    wait_valid(cyc, 10);
    push_exp(32'h3000_0100);
    ack(1'b0, 32'h0, 1'b1, 26'h0000040, 1'b1, 16'h0005, 1'b1);
    check("jump_over_br", imem_addr, 32'h3000_0100);
    wait_valid(cyc, 10);
    push_exp(32'h200);
    ack(1'b1, 32'h200, 1'b1, 26'h3FF_FFFF, 1'b1, 16'h0010, 1'b1);
    check("jr_over_jump", imem_addr, 32'h200);
    wait_valid(cyc, 10);

    // Wrap-around of pc + 4.
    push_exp(32'hFFFF_FFFC);
    ack(1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0, 1'b0, 16'h0, 1'b1);
    wait_valid(cyc, 10);
    push_exp(32'h0);
    ack(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b1);
    check("wrap", imem_addr, 32'h0);
    wait_valid(cyc, 10);

    // Memory wait states; ack during fetch must be ignored.
    imem_ready = 1'b0;
    push_exp(32'h4);
    ack(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_addr", imem_addr, 32'h4);
      instr_ack = 1'b1;
      jr        = 1'b1;
      jr_target = 32'h500;
      tick();
    end
    instr_ack  = 1'b0;
    jr         = 1'b0;
    imem_ready = 1'b1;
    check("wait_req_last", {31'd0, imem_req}, 32'd1);
    check("wait_addr_last", imem_addr, 32'h4);
    wait_valid(cyc, 10);
    check("ack_in_fetch_ignored", pc, 32'h4);

    // Reset in the middle of an outstanding fetch.
    imem_ready = 1'b0;
    ack(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_pc", pc, 32'h0);
    check("midrst_instr", instr, 32'h0);
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    push_exp(32'h0);
    rst        = 1'b0;
    imem_ready = 1'b1;
    tick();
    check("midrst_idle_valid", {31'd0, instr_valid}, 32'd0);
    check("restart_req", {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, 32'h0);
    wait_valid(cyc, 10);

    // Misaligned jr target.
`ifdef FETCH_MISALIGN_TRAP_EN
    ack(1'b1, 32'h0000_0102, 1'b0, 26'h0, 1'b0, 16'h0, 1'b0);
    check("trap_addr_err", {31'd0, addr_err}, 32'd1);
    check("trap_valid", {31'd0, instr_valid}, 32'd0);
    check("trap_pc", pc, 32'h0);
    for (int k = 0; k < 3; k++) tick();
    check("trap_hold_err", {31'd0, addr_err}, 32'd1);
    check("trap_hold_req", {31'd0, imem_req}, 32'd0);
`else
    push_exp(32'h100);
    ack(1'b1, 32'h0000_0102, 1'b0, 26'h0, 1'b0, 16'h0, 1'b1);
    check("jr_aligned", imem_addr, 32'h100);
    wait_valid(cyc, 10);
    check("no_addr_err", {31'd0, addr_err}, 32'd0);
`endif

    tick();
    tick();
    check("queue_empty", q_addr.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the single-cycle MIPS CPU, directly upstream of the opcode decoder. Owns the program counter, fetches one 32-bit word per instruction from instruction memory over a request/ready handshake, and presents the instruction and its 6-bit opcode field to the decoder until the downstream datapath acknowledges it. On acknowledge it computes the next PC (sequential, branch, jump, jump-register) and starts the next fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request, held high until imem_ready
- imem_addr  out  32  byte address of requested word (= pc)
- imem_ready  in  1  imem_rdata valid this cycle; sampled only while imem_req=1
- imem_rdata  in  32  fetched instruction word
- instr  out  32  registered instruction word
- op  out  6  instr[31:26], feeds the decoder
- pc  out  32  address of instr
- pc_plus4  out  32  pc + 4 (link value for jal)
- instr_valid  out  1  instr/op/pc are valid
- instr_ack  in  1  downstream consumed instr; next-PC inputs valid this cycle
- br_taken  in  1  conditional branch taken (beq/bne resolved)
- br_imm  in  16  branch immediate
- jump  in  1  j/jal
- jump_idx  in  26  jump target field
- jr  in  1  jump register
- jr_target  in  32  register-sourced target
- addr_err  out  1  misaligned jr target trap (see Configuration)

## Operation
- States: IDLE, FETCH, HOLD, ERR (ERR only with macro).
- IDLE: one cycle after reset release; -> FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_ready: instr <= imem_rdata, -> HOLD.
- HOLD: instr_valid=1, instr stable. instr_ack ignored in any other state. On instr_ack: pc <= next_pc, -> FETCH.
- next_pc priority: jr > jump > br_taken > sequential.
  - sequential: pc + 4
  - branch: pc + 4 + (sign_extend(br_imm) << 2)
  - jump: {pc_plus4[31:28], jump_idx, 2'b00}
  - jr: jr_target
- All additions 32-bit, modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Multiple control inputs asserted together: priority resolves, no error.
- Reset values: pc=RESET_PC, instr=0, state=IDLE, imem_req=0, instr_valid=0, addr_err=0.
- Reset mid-operation (any state): immediate return to reset values; an outstanding imem request is abandoned, a late imem_ready is ignored.

## Timing
- Reset release at edge 0: IDLE through edge 1, FETCH from edge 1; with imem_ready tied high, instr_valid rises after edge 2.
- Memory latency: instr registered on the edge where imem_req && imem_ready; instr_valid the cycle after.
- Ack to next request: 1 cycle (imem_req high the cycle after instr_ack).
- Peak throughput: one instruction per 2 cycles with zero-wait memory and ack in first HOLD cycle.
- op, pc_plus4 derived combinationally from registered instr and pc; no extra latency.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: a jr acknowledge with jr_target[1:0] != 0 loads no PC, enters ERR; addr_err=1, imem_req=0, instr_valid=0 until reset.
- Undefined: jr_target[1:0] forced to 0, ERR state absent, addr_err tied 0.

## Structure
- Shared package cpu_pkg: OP_W=6, INSTR_W=32, default RESET_PC, fetch state enum.
- One sub-module: next_pc_calc (combinational priority mux plus branch/jump adders); instruction_fetch holds state machine and registers.

## Test plan
- Reset, imem_ready=1, instr_ack every HOLD cycle -> imem_addr sequence 0,4,8,12; instr_valid every other cycle.
- In HOLD at pc=0x100, ack with br_taken=1, br_imm=16'hFFFE -> next imem_addr=0x0FC; br_imm=0x0003 -> 0x110.
- pc=0x3000_0010, ack with jump=1, jump_idx=26'h0000040 -> next imem_addr=0x3000_0100; same cycle br_taken=1 ignored.
- imem_ready delayed 3 cycles -> imem_req and imem_addr stable for all 4 cycles; instr_ack during FETCH has no effect.
- rst asserted mid-FETCH, late imem_ready after release -> pc=RESET_PC, instr=0, instr_valid=0, fetch restarts from RESET_PC.
- jr_target=0x0000_0102 on ack -> with FETCH_MISALIGN_TRAP_EN: addr_err=1, imem_req held 0; without: next imem_addr=0x0000_0100.
